pattern_player: RTL

Generates the game's pseudo-random pattern and plays it to the user as a timed serial bit stream (LED/buzzer drive). It is the transmit-side counterpart of the input handler: it emits `count` bits MSB-first, and the input handler shifts the user's echo back in MSB-first. It sits between the classic-mode FSM (`gen_pattern` / `done_gen_pattern` handshake) and the comparator, which consumes `game_pattern`.

---
 rtl/pattern_player.sv | 137 +++++++++++++
 1 files changed

// File: rtl/pattern_player.sv
// Generates an LFSR-derived game pattern and plays it MSB-first as timed bit slots
// on out/out_valid, with a start/done handshake toward the game FSM.
//
// state  | meaning
// IDLE   | waiting for gen_pattern; LFSR free-running
// BIT    | presenting game_pattern[idx] on out for BIT_CYCLES
// GAP    | idle spacing after a bit for GAP_CYCLES
// DONE   | one-cycle done_gen_pattern pulse, then back to IDLE
module pattern_player #(
    parameter int               WIDTH      = 16,
    parameter int               BIT_CYCLES = 4,
    parameter int               GAP_CYCLES = 2,
    parameter logic [WIDTH-1:0] SEED       = WIDTH'(16'hACE1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             gen_pattern,
    input  logic [15:0]      count,
    output logic [WIDTH-1:0] game_pattern,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done_gen_pattern
);

    localparam int LW   = $clog2(WIDTH + 1);
    localparam int IW   = $clog2(WIDTH);
    localparam int CMAX = (BIT_CYCLES > GAP_CYCLES) ? BIT_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [WIDTH-1:0] POLY = WIDTH'(16'hB400);

    typedef enum logic [1:0] {S_IDLE, S_BIT, S_GAP, S_DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] lfsr_q;
    logic [CW-1:0]    cnt;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    idx_dn;
    logic [LW-1:0]    len_c;
    logic [IW-1:0]    first_idx;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] cap;

    // Galois LFSR runs in every state so the pattern depends on when play starts.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else if (lfsr_q[0]) begin
            lfsr_q <= (lfsr_q >> 1) ^ POLY;
        end else begin
            lfsr_q <= lfsr_q >> 1;
        end
    end

    always_comb begin
        len_c = (count > 16'(WIDTH)) ? LW'(WIDTH) : LW'(count);
        mask  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            mask[i] = (i < int'(len_c));
        end
        cap       = lfsr_q & mask;
        first_idx = IW'(len_c - LW'(1));
        idx_dn    = idx - IW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            cnt              <= '0;
            idx              <= '0;
            game_pattern     <= '0;
            out              <= 1'b0;
            out_valid        <= 1'b0;
            busy             <= 1'b0;
            done_gen_pattern <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (gen_pattern) begin
                        game_pattern <= cap;
                        busy         <= 1'b1;
                        if (len_c == '0) begin
                            state            <= S_DONE;
                            done_gen_pattern <= 1'b1;
                        end else begin
                            state     <= S_BIT;
                            idx       <= first_idx;
                            cnt       <= CW'(BIT_CYCLES - 1);
                            out       <= cap[first_idx];
                            out_valid <= 1'b1;
                        end
                    end
                end
                S_BIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else if (GAP_CYCLES != 0) begin
                        state     <= S_GAP;
                        cnt       <= CW'(GAP_CYCLES - 1);
                        out       <= 1'b0;
                        out_valid <= 1'b0;
                    end else if (idx == '0) begin
                        state            <= S_DONE;
                        done_gen_pattern <= 1'b1;
                        out              <= 1'b0;
                        out_valid        <= 1'b0;
                    end else begin
                        idx <= idx_dn;
                        cnt <= CW'(BIT_CYCLES - 1);
                        out <= game_pattern[idx_dn];
                    end
                end
                S_GAP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else if (idx == '0) begin
                        state            <= S_DONE;
                        done_gen_pattern <= 1'b1;
                    end else begin
                        state     <= S_BIT;
                        idx       <= idx_dn;
                        cnt       <= CW'(BIT_CYCLES - 1);
                        out       <= game_pattern[idx_dn];
                        out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    state            <= S_IDLE;
                    done_gen_pattern <= 1'b0;
                    busy             <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
